uart_param: RTL and testbench



---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_param.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_param.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: parity modes, FSM states and
// the parity helper used by both the transmitter and the receiver.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Frame parity bit for a data word; narrower words are zero-extended,
  // which leaves the XOR reduction unchanged.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    case (mode)
      PARITY_ODD:  return ~^data;
      PARITY_EVEN: return ^data;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick generator: counts 0..div and pulses on the terminal count.
// The divisor is captured only on restart so a frame in flight keeps its rate.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] div_q;

  // Free-running counter, realigned to zero by restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= '0;
    end else if (restart_i) begin
      cnt_q <= '0;
      div_q <= div_i;
    end else if (cnt_q == div_q) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == div_q);

endmodule

// File: rtl/uart_param.sv
// Full-duplex UART with valid/ready byte ports, runtime divisor and an
// oversampled majority-vote receiver.
//
// state     | meaning
// IDLE      | line idle, waiting for a byte (TX) or a falling edge (RX)
// START     | start bit
// DATA      | data bits, LSB first
// PARITY    | parity bit (only when PARITY != 0)
// STOP      | stop bit(s); RX leaves as soon as the first stop is decided
module uart_param import uart_pkg::*; #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  output logic                 tx_busy,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] S_0    = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] S_1    = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] S_2    = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [2:0]    D_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    P_LAST = 3'(STOP_BITS - 1);

  // ---------------- transmitter ----------------
  tx_state_e              tx_state_q;
  logic [TW-1:0]          tx_tcnt_q;
  logic [2:0]             tx_bcnt_q;
  logic [DATA_BITS-1:0]   tx_shift_q;
  logic                   tx_par_q;
  logic                   tx_q;
  logic                   tx_tick, tx_bit_end, tx_last_stop, tx_accept;

  assign tx_bit_end   = tx_tick & (tx_tcnt_q == T_LAST);
  assign tx_last_stop = (tx_state_q == TX_STOP) & (tx_bcnt_q == P_LAST);
  // Ready also in the final clk of the last stop bit so streaming has no gap.
  assign tx_ready     = ~rst & ((tx_state_q == TX_IDLE) | (tx_last_stop & tx_bit_end));
  assign tx_accept    = tx_valid & tx_ready;
  assign tx           = tx_q;
  assign tx_busy      = (tx_state_q != TX_IDLE);

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tx_tick (
    .clk       (clk),
    .rst       (rst),
    .restart_i (tx_accept),
    .div_i     (div),
    .tick_o    (tx_tick)
  );

  // TX frame sequencer; the line value is registered and changes on bit ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_tcnt_q  <= '0;
      tx_bcnt_q  <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      if (tx_accept)    tx_tcnt_q <= '0;
      else if (tx_tick) tx_tcnt_q <= (tx_tcnt_q == T_LAST) ? '0 : tx_tcnt_q + 1'b1;

      if (tx_accept) begin
        tx_shift_q <= tx_data;
        tx_par_q   <= parity_bit(8'(tx_data), PARITY);
        tx_bcnt_q  <= '0;
        tx_q       <= 1'b0;
        tx_state_q <= TX_START;
      end else if (tx_bit_end) begin
        case (tx_state_q)
          TX_START: begin
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_state_q <= TX_DATA;
          end
          TX_DATA: begin
            if (tx_bcnt_q == D_LAST) begin
              tx_bcnt_q <= '0;
              if (PARITY != PARITY_NONE) begin
                tx_q       <= tx_par_q;
                tx_state_q <= TX_PARITY;
              end else begin
                tx_q       <= 1'b1;
                tx_state_q <= TX_STOP;
              end
            end else begin
              tx_bcnt_q  <= tx_bcnt_q + 1'b1;
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
            end
          end
          TX_PARITY: begin
            tx_q       <= 1'b1;
            tx_state_q <= TX_STOP;
          end
          TX_STOP: begin
            if (tx_last_stop) tx_state_q <= TX_IDLE;
            else              tx_bcnt_q  <= tx_bcnt_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- receiver ----------------
  rx_state_e              rx_state_q;
  logic                   rx_s1_q, rx_s2_q, rx_s3_q;
  logic [TW-1:0]          rx_tcnt_q;
  logic [2:0]             rx_bcnt_q;
  logic [DATA_BITS-1:0]   rx_shift_q;
  logic [1:0]             rx_samp_q;
  logic                   rx_pe_q;
  logic                   rx_tick, rx_fall, rx_restart, rx_bit_end, rx_decide, rx_maj, rx_done;
  logic                   rx_valid_q, rx_fe_out_q, rx_pe_out_q, rx_ov_q;
  logic [DATA_BITS-1:0]   rx_data_q;

  assign rx_fall    = ~rx_s2_q & rx_s3_q;
  assign rx_restart = (rx_state_q == RX_IDLE) & rx_fall;
  assign rx_bit_end = rx_tick & (rx_tcnt_q == T_LAST);
  assign rx_decide  = rx_tick & (rx_tcnt_q == S_2);
  assign rx_maj     = (rx_samp_q[0] & rx_samp_q[1]) | (rx_samp_q[0] & rx_s2_q) |
                      (rx_samp_q[1] & rx_s2_q);
  assign rx_done    = (rx_state_q == RX_STOP) & rx_decide;
  assign rx_busy    = (rx_state_q != RX_IDLE);

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_rx_tick (
    .clk       (clk),
    .rst       (rst),
    .restart_i (rx_restart),
    .div_i     (div),
    .tick_o    (rx_tick)
  );

  // Synchroniser, sample capture and RX frame sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_tcnt_q  <= '0;
      rx_bcnt_q  <= '0;
      rx_shift_q <= '0;
      rx_samp_q  <= '0;
      rx_pe_q    <= 1'b0;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;

      if (rx_restart)   rx_tcnt_q <= '0;
      else if (rx_tick) rx_tcnt_q <= (rx_tcnt_q == T_LAST) ? '0 : rx_tcnt_q + 1'b1;

      if (rx_tick && rx_tcnt_q == S_0) rx_samp_q[0] <= rx_s2_q;
      if (rx_tick && rx_tcnt_q == S_1) rx_samp_q[1] <= rx_s2_q;

      case (rx_state_q)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_bcnt_q  <= '0;
            rx_pe_q    <= 1'b0;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_decide && rx_maj) rx_state_q <= RX_IDLE;
          else if (rx_bit_end)     rx_state_q <= RX_DATA;
        end
        RX_DATA: begin
          if (rx_decide) rx_shift_q <= {rx_maj, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_end) begin
            if (rx_bcnt_q == D_LAST) begin
              rx_bcnt_q  <= '0;
              rx_state_q <= (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
            end else begin
              rx_bcnt_q <= rx_bcnt_q + 1'b1;
            end
          end
        end
        RX_PARITY: begin
          if (rx_decide)  rx_pe_q    <= rx_maj ^ parity_bit(8'(rx_shift_q), PARITY);
          if (rx_bit_end) rx_state_q <= RX_STOP;
        end
        RX_STOP: begin
          if (rx_decide) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Output holding register with overrun detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_fe_out_q <= 1'b0;
      rx_pe_out_q <= 1'b0;
      rx_ov_q     <= 1'b0;
    end else begin
      rx_ov_q <= 1'b0;
      if (rx_done) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q   <= rx_shift_q;
          rx_fe_out_q <= ~rx_maj;
          rx_pe_out_q <= rx_pe_q;
          rx_valid_q  <= 1'b1;
        end else begin
          rx_ov_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_valid      = rx_valid_q;
  assign rx_data       = rx_data_q;
  assign rx_frame_err  = rx_fe_out_q;
  assign rx_parity_err = rx_pe_out_q;
  assign rx_overrun    = rx_ov_q;

endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param: an 8N1 instance (TX waveform, glitch, overrun, reset)
// and an 8E1 instance (loopback and injected error frames). Received bytes
// are checked by per-instance scoreboard monitors.
module tb_uart_param;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          ov_n = 0;
  int          ov_e = 0;
  exp_t        q_n[$];
  exp_t        q_e[$];

  // 8N1 instance
  logic [15:0] div_n;
  logic        rx_n, tx_n, txv_n, txr_n, rxv_n, rxr_n, rfe_n, rpe_n, rov_n, txb_n, rxb_n;
  logic [7:0]  txd_n, rxd_n;
  // 8E1 instance
  logic [15:0] div_e;
  logic        rx_e, tx_e, txv_e, txr_e, rxv_e, rxr_e, rfe_e, rpe_e, rov_e, txb_e, rxb_e;
  logic [7:0]  txd_e, rxd_e;
  logic        lb_sel, inj_e;

  assign rx_e = lb_sel ? tx_e : inj_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_WIDTH(16)) u_n (
    .clk(clk), .rst(rst), .div(div_n), .rx(rx_n), .tx(tx_n),
    .tx_valid(txv_n), .tx_ready(txr_n), .tx_data(txd_n),
    .rx_valid(rxv_n), .rx_ready(rxr_n), .rx_data(rxd_n),
    .rx_frame_err(rfe_n), .rx_parity_err(rpe_n), .rx_overrun(rov_n),
    .tx_busy(txb_n), .rx_busy(rxb_n)
  );

  uart_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_WIDTH(16)) u_e (
    .clk(clk), .rst(rst), .div(div_e), .rx(rx_e), .tx(tx_e),
    .tx_valid(txv_e), .tx_ready(txr_e), .tx_data(txd_e),
    .rx_valid(rxv_e), .rx_ready(rxr_e), .rx_data(rxd_e),
    .rx_frame_err(rfe_e), .rx_parity_err(rpe_e), .rx_overrun(rov_e),
    .tx_busy(txb_e), .rx_busy(rxb_e)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor, 8N1 instance.
  initial forever begin
    @(negedge clk);
    if (!rst && rxv_n && rxr_n) begin
      if (q_n.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_n_unexpected: actual=%0h expected=none", rxd_n);
      end else begin
        exp_t x;
        x = q_n.pop_front();
        check("rx_n_frame", {22'd0, rxd_n, rfe_n, rpe_n}, {22'd0, x.d, x.fe, x.pe});
      end
    end
  end

  // Scoreboard monitor, 8E1 instance.
  initial forever begin
    @(negedge clk);
    if (!rst && rxv_e && rxr_e) begin
      if (q_e.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_e_unexpected: actual=%0h expected=none", rxd_e);
      end else begin
        exp_t x;
        x = q_e.pop_front();
        check("rx_e_frame", {22'd0, rxd_e, rfe_e, rpe_e}, {22'd0, x.d, x.fe, x.pe});
      end
    end
  end

  // Overrun pulse counters.
  initial forever begin
    @(negedge clk);
    if (rov_n) ov_n++;
    if (rov_e) ov_e++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic line(input bit e, input logic v, input int n);
    if (e) inj_e = v; else rx_n = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic inj_frame(input bit e, input logic [7:0] d, input bit use_par,
                           input logic par, input logic stop);
    line(e, 1'b0, 16);
    for (int i = 0; i < 8; i++) line(e, d[i], 16);
    if (use_par) line(e, par, 16);
    line(e, stop, 16);
  endtask

  // Call at a negedge; returns at the first negedge where tx_ready is high.
  task automatic wait_txr(input bit e);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (e ? txr_e : txr_n) ok = 1'b1;
      else @(negedge clk);
    end
    check("tx_ready_wait", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_empty(input bit e, input int bound);
    int n;
    n = 0;
    while ((e ? q_e.size() : q_n.size()) != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(e ? "q_e_drained" : "q_n_drained", e ? q_e.size() : q_n.size(), 0);
  endtask

  task automatic tx_accept_n(input logic [7:0] d);
    @(negedge clk);
    txd_n = d;
    txv_n = 1'b1;
    wait_txr(1'b0);
    @(posedge clk);
    #1;
    txv_n = 1'b0;
  endtask

  // Waveform of one 8N1 frame starting the clk after acceptance.
  task automatic tx_wave(input logic [7:0] d, input int tb);
    int   errs, rise;
    logic e;
    errs = 0;
    rise = 0;
    for (int k = 1; k <= 10 * tb; k++) begin
      @(negedge clk);
      if (k <= tb)          e = 1'b0;
      else if (k <= 9 * tb) e = d[(k - tb - 1) / tb];
      else                  e = 1'b1;
      if (tx_n !== e) errs++;
      if (rise == 0 && txr_n) rise = k;
    end
    check("tx_wave_errs", errs, 0);
    check("tx_ready_rise", rise, 10 * tb);
  endtask

  initial begin
    logic [7:0] lb_bytes [3];
    logic [2:0] lb_par;
    int         acc_cyc, prev_cyc;
    bit         seen_busy, any_valid;

    rst = 1'b1;
    div_n = '0; rx_n = 1'b1; txv_n = 1'b0; txd_n = '0; rxr_n = 1'b1;
    div_e = '0; txv_e = 1'b0; txd_e = '0; rxr_e = 1'b1; lb_sel = 1'b0; inj_e = 1'b1;
    prev_cyc = 0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx_n}, 32'd1);
    check("rst_tx_ready", {31'd0, txr_n}, 32'd0);
    check("rst_rx_valid", {31'd0, rxv_n}, 32'd0);
    check("rst_rx_data", {24'd0, rxd_n}, 32'd0);
    check("rst_flags", {29'd0, rfe_n, rpe_n, rov_n}, 32'd0);
    check("rst_busy", {28'd0, txb_n, rxb_n, txb_e, rxb_e}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("tx_ready_after_rst", {30'd0, txr_n, txr_e}, 32'd3);

    // 8N1 TX waveform, div=0
    tx_accept_n(8'hA5);
    tx_wave(8'hA5, 16);

    // Short low glitch is a false start
    @(posedge clk); #1;
    seen_busy = 1'b0;
    any_valid = 1'b0;
    line(1'b0, 1'b0, 4);
    rx_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      seen_busy |= rxb_n;
      any_valid |= rxv_n | rov_n;
    end
    check("glitch_busy_seen", {31'd0, seen_busy}, 32'd1);
    check("glitch_no_valid", {31'd0, any_valid}, 32'd0);
    check("glitch_busy_end", {31'd0, rxb_n}, 32'd0);

    // Overrun: two frames with the consumer stalled
    @(posedge clk); #1;
    rxr_n = 1'b0;
    ov_n = 0;
    q_n.push_back('{d: 8'h11, fe: 1'b0, pe: 1'b0});
    inj_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    inj_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    line(1'b0, 1'b1, 40);
    check("ovr_valid_held", {31'd0, rxv_n}, 32'd1);
    check("ovr_data_kept", {24'd0, rxd_n}, 32'h11);
    check("ovr_pulses", ov_n, 1);
    @(posedge clk); #1;
    rxr_n = 1'b1;
    wait_empty(1'b0, 50);
    line(1'b0, 1'b1, 60);
    check("ovr_no_more_data", {31'd0, rxv_n}, 32'd0);
    check("ovr_pulses_final", ov_n, 1);

    // 8E1 loopback, back-to-back
    lb_bytes[0] = 8'h00; lb_bytes[1] = 8'h07; lb_bytes[2] = 8'hFF;
    lb_par = 3'b010;
    lb_sel = 1'b1;
    @(negedge clk);
    txv_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      txd_e = lb_bytes[i];
      wait_txr(1'b1);
      @(posedge clk); #1;
      acc_cyc = cyc;
      q_e.push_back('{d: lb_bytes[i], fe: 1'b0, pe: 1'b0});
      if (i > 0) check("lb_frame_gap", acc_cyc - prev_cyc, 176);
      prev_cyc = acc_cyc;
      repeat (152) @(negedge clk);
      check("lb_parity_bit", {31'd0, tx_e}, {31'd0, lb_par[i]});
    end
    txv_e = 1'b0;
    wait_empty(1'b1, 400);
    repeat (40) @(negedge clk);

    // Injected error frames on the 8E1 receiver
    lb_sel = 1'b0;
    @(posedge clk); #1;
    q_e.push_back('{d: 8'h5A, fe: 1'b1, pe: 1'b0});
    inj_frame(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    line(1'b1, 1'b1, 32);
    q_e.push_back('{d: 8'h3C, fe: 1'b0, pe: 1'b1});
    inj_frame(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
    q_e.push_back('{d: 8'h81, fe: 1'b0, pe: 1'b0});
    inj_frame(1'b1, 8'h81, 1'b1, 1'b0, 1'b1);
    line(1'b1, 1'b1, 32);
    wait_empty(1'b1, 200);
    check("e_no_overrun", ov_e, 0);

    // Reset in the middle of a transmission, div=3
    div_n = 16'd3;
    tx_accept_n(8'h3C);
    repeat (100) @(negedge clk);
    check("pre_rst_tx_bit0", {31'd0, tx_n}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx_line", {31'd0, tx_n}, 32'd1);
    check("rst_mid_tx_ready", {31'd0, txr_n}, 32'd0);
    check("rst_mid_tx_busy", {31'd0, txb_n}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready_back", {31'd0, txr_n}, 32'd1);
    tx_accept_n(8'h5A);
    tx_wave(8'h5A, 64);

    repeat (20) @(negedge clk);
    check("q_n_final_empty", q_n.size(), 0);
    check("q_e_final_empty", q_e.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
